// File: rtl/cpu_pkg.sv
// Shared definitions for the 8-bit CPU front end.
//   ADDR_W / IMEM_DEPTH : PC width and instruction memory depth (power of 2)
//   OP_*, IMM6_*        : instruction field positions; OP_JUMP marks a fetch-resolved jump
//   PC_MASK             : reduces any PC modulo IMEM_DEPTH
//   ifid_t              : IF/ID pipeline register contents
package cpu_pkg;
  localparam int ADDR_W     = 8;
  localparam int IMEM_DEPTH = 32;

  localparam int OP_MSB   = 7;
  localparam int OP_LSB   = 6;
  localparam int IMM6_MSB = 5;
  localparam int IMM6_LSB = 0;

  localparam logic [1:0]        OP_JUMP = 2'b11;
  localparam logic [ADDR_W-1:0] PC_MASK = ADDR_W'(IMEM_DEPTH - 1);

  typedef struct packed {
    logic              valid;
    logic [7:0]        instr;
    logic [ADDR_W-1:0] pc;
  } ifid_t;
endpackage

// File: rtl/pc_next.sv
// Next-PC computation for fetch. Pure combinational.
//   pc      in  current fetch address
//   instr   in  byte fetched from pc
//   next_pc out pc+1, or pc+1+sext(imm6) for JUMP, reduced mod IMEM_DEPTH
module pc_next
  import cpu_pkg::*;
(
  input  logic [ADDR_W-1:0] pc,
  input  logic [7:0]        instr,
  output logic [ADDR_W-1:0] next_pc
);
  logic              is_jump;
  logic [ADDR_W-1:0] imm_ext;
  logic [ADDR_W-1:0] offs;
  logic [ADDR_W-1:0] sum;

  always_comb begin
    is_jump = (instr[OP_MSB:OP_LSB] == OP_JUMP);
    imm_ext = {{(ADDR_W-6){instr[IMM6_MSB]}}, instr[IMM6_MSB:IMM6_LSB]};
    offs    = is_jump ? imm_ext : '0;
    // Sum wraps in ADDR_W bits first; the mask then folds it into memory range.
    sum     = pc + ADDR_W'(1) + offs;
    next_pc = sum & PC_MASK;
  end
endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, reads instruction memory combinationally,
// captures the byte into the IF/ID register and hands it to decode via valid/ready.
// Jumps are resolved here so a taken jump adds no bubble; redirects from later
// stages override everything and flush the IF/ID register.
//   clk, rst_n      clock, async active-low reset
//   pc_addr         instruction memory read address (current PC)
//   imem_instr      byte at pc_addr, same cycle
//   redirect_valid  / redirect_pc : PC override from later stages
//   id_valid/id_ready/id_instr/id_pc : IF/ID handshake to decode
//   fetch_count     saturating count of accepted handshakes
module fetch_unit
  import cpu_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic [ADDR_W-1:0] pc_addr,
  input  logic [7:0]        imem_instr,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              id_valid,
  input  logic              id_ready,
  output logic [7:0]        id_instr,
  output logic [ADDR_W-1:0] id_pc,
  output logic [CNT_W-1:0]  fetch_count
);
  logic [ADDR_W-1:0] pc_q, pc_d;
  ifid_t             ifid_q, ifid_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] next_pc;
  logic              load;
  logic              hs;

  pc_next u_pc_next (
    .pc      (pc_q),
    .instr   (imem_instr),
    .next_pc (next_pc)
  );

  always_comb begin
    load   = !ifid_q.valid || id_ready;
    hs     = ifid_q.valid && id_ready;
    pc_d   = pc_q;
    ifid_d = ifid_q;
    cnt_d  = cnt_q;

    // A handshake still counts when a redirect flushes the register that edge.
    if (hs && (cnt_q != '1)) cnt_d = cnt_q + CNT_W'(1);

    if (redirect_valid) begin
      pc_d         = redirect_pc & PC_MASK;
      ifid_d.valid = 1'b0;
    end else if (load) begin
      ifid_d.valid = 1'b1;
      ifid_d.instr = imem_instr;
      ifid_d.pc    = pc_q;
      pc_d         = next_pc;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q   <= '0;
      ifid_q <= '0;
      cnt_q  <= '0;
    end else begin
      pc_q   <= pc_d;
      ifid_q <= ifid_d;
      cnt_q  <= cnt_d;
    end
  end

  assign pc_addr     = pc_q;
  assign id_valid    = ifid_q.valid;
  assign id_instr    = ifid_q.instr;
  assign id_pc       = ifid_q.pc;
  assign fetch_count = cnt_q;
endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed program scenarios with literal expectations,
// then randomized ready/redirect/reset traffic, all cross-checked every cycle
// against an arithmetic model of the fetch rules.
module tb_fetch_unit;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic [7:0]    pc_addr;
  logic [7:0]    imem_instr;
  logic          redirect_valid = 1'b0;
  logic [7:0]    redirect_pc = '0;
  logic          id_valid;
  logic          id_ready = 1'b0;
  logic [7:0]    id_instr;
  logic [7:0]    id_pc;
  logic [CW-1:0] fetch_count;

  logic [7:0] mem [32];
  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  // Model state
  int         m_pc = 0;
  bit         m_valid = 1'b0;
  logic [7:0] m_instr = '0;
  int         m_idpc = 0;
  int         m_cnt = 0;

  always #5 clk = ~clk;

  assign imem_instr = mem[pc_addr[4:0]];

  fetch_unit #(.CNT_W(CW)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .pc_addr        (pc_addr),
    .imem_instr     (imem_instr),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .id_valid       (id_valid),
    .id_ready       (id_ready),
    .id_instr       (id_instr),
    .id_pc          (id_pc),
    .fetch_count    (fetch_count)
  );

  function automatic int nxt(int pc, logic [7:0] ins);
    int imm;
    imm = 0;
    if (ins[7:6] == 2'b11) begin
      imm = int'(ins[5:0]);
      if (imm >= 32) imm = imm - 64;
    end
    return (((pc + 1 + imm) % 32) + 32) % 32;
  endfunction

  // Reference behaviour: redirect beats load beats hold; counter saturates.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_pc = 0; m_valid = 0; m_instr = '0; m_idpc = 0; m_cnt = 0;
    end else begin
      if (m_valid && id_ready && m_cnt < (1 << CW) - 1) m_cnt = m_cnt + 1;
      if (redirect_valid) begin
        m_pc    = int'(redirect_pc) % 32;
        m_valid = 0;
      end else if (!m_valid || id_ready) begin
        m_instr = mem[m_pc];
        m_idpc  = m_pc;
        m_valid = 1;
        m_pc    = nxt(m_pc, mem[m_pc]);
      end
    end
  end

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("pc_addr",     32'(pc_addr),     32'(m_pc));
      chk("id_valid",    32'(id_valid),    32'(m_valid));
      chk("id_instr",    32'(id_instr),    32'(m_instr));
      chk("id_pc",       32'(id_pc),       32'(m_idpc));
      chk("fetch_count", 32'(fetch_count), 32'(m_cnt));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  // Edges 1-4 after release with decode always ready; 0xCD jumps +13 from 2 to 16.
  task automatic run_seq1(string tag);
    id_ready = 1'b1;
    step(); chk({tag, "_e1_instr"}, 32'(id_instr), 32'h85); chk({tag, "_e1_pc"}, 32'(id_pc), 32'd0);
    step(); chk({tag, "_e2_instr"}, 32'(id_instr), 32'h58); chk({tag, "_e2_pc"}, 32'(id_pc), 32'd1);
    step(); chk({tag, "_e3_instr"}, 32'(id_instr), 32'hCD); chk({tag, "_e3_pc"}, 32'(id_pc), 32'd2);
    step(); chk({tag, "_e4_instr"}, 32'(id_instr), 32'h2C); chk({tag, "_e4_pc"}, 32'(id_pc), 32'd16);
    chk({tag, "_e4_cnt"}, 32'(fetch_count), 32'd3);
  endtask

  initial begin
    for (int i = 0; i < 32; i++) mem[i] = 8'($urandom);
    mem[0] = 8'h85; mem[1] = 8'h58; mem[2] = 8'hCD; mem[3] = 8'h83;
    mem[16] = 8'h2C; mem[30] = 8'h7F; mem[31] = 8'hDE;

    #1 rst_n = 1'b0;
    #1 cmp_en = 1'b1;
    step();
    chk("rst_pc",    32'(pc_addr),     32'd0);
    chk("rst_valid", 32'(id_valid),    32'd0);
    chk("rst_instr", 32'(id_instr),    32'd0);
    chk("rst_idpc",  32'(id_pc),       32'd0);
    chk("rst_cnt",   32'(fetch_count), 32'd0);
    step();
    rst_n = 1'b1;

    // 1: straight-line fetch through a jump
    run_seq1("seq1");

    // 2: decode stalls for three cycles after edge 2
    do_reset();
    id_ready = 1'b1;
    step(); step();
    id_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("hold_instr", 32'(id_instr), 32'h58);
      chk("hold_pc",    32'(pc_addr),  32'd2);
    end
    id_ready = 1'b1;
    step();
    chk("rel_instr", 32'(id_instr),    32'hCD);
    chk("rel_idpc",  32'(id_pc),       32'd2);
    chk("rel_cnt",   32'(fetch_count), 32'd2);

    // 3: redirect to 30 while stalled
    id_ready = 1'b0; redirect_valid = 1'b1; redirect_pc = 8'd30;
    step();
    chk("redir_valid", 32'(id_valid), 32'd0);
    chk("redir_pc",    32'(pc_addr),  32'd30);
    redirect_valid = 1'b0; id_ready = 1'b1;
    step();
    chk("r30_instr", 32'(id_instr), 32'h7F);
    chk("r30_idpc",  32'(id_pc),    32'd30);
    step();
    chk("r31_instr", 32'(id_instr), 32'hDE);
    chk("r31_idpc",  32'(id_pc),    32'd31);
    // 0xDE: imm6 = 6'b011110 = +30, so 31+1+30 = 62 -> 30 mod 32.
    chk("jmp_wrap_pc", 32'(pc_addr), 32'd30);

    // 4: redirect target beyond memory folds mod 32
    redirect_valid = 1'b1; redirect_pc = 8'd35;
    step();
    chk("r35_pc", 32'(pc_addr), 32'd3);
    redirect_valid = 1'b0;
    step();
    chk("r35_instr", 32'(id_instr), 32'h83);
    chk("r35_idpc",  32'(id_pc),    32'd3);

    // 5: reset asserted between clock edges clears state immediately
    #2 rst_n = 1'b0;
    #1;
    chk("arst_pc",    32'(pc_addr),     32'd0);
    chk("arst_valid", 32'(id_valid),    32'd0);
    chk("arst_cnt",   32'(fetch_count), 32'd0);
    step();
    rst_n = 1'b1;
    run_seq1("seq5");

    // 6: counter saturation
    for (int i = 0; i < 20; i++) step();
    chk("cnt_sat", 32'(fetch_count), 32'hF);

    // Randomized traffic, compared every cycle against the model
    for (int i = 0; i < 3000; i++) begin
      id_ready       = ($urandom_range(0, 99) < 70);
      redirect_valid = ($urandom_range(0, 99) < 10);
      redirect_pc    = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 499) == 0) begin
        #3 rst_n = 1'b0;
        step();
        rst_n = 1'b1;
      end else begin
        step();
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
